imem_sync: RTL

Parametrised synchronous instruction memory with a valid/ready fetch port, a response FIFO for backpressure, a flush for redirects, and a byte-strobed load port for boot-time programming. It sits between the fetch stage and the instruction store, replacing the combinational word-read memory. Fetch issues byte addresses; the block returns 32-bit words, or an error response for misaligned or out-of-window addresses.

---
 rtl/imem_sync.sv | 133 +++++++++++++
 1 files changed

// File: rtl/imem_sync.sv
// Synchronous instruction memory with valid/ready fetch, FWFT response FIFO,
// flush for redirects and a byte-strobed boot load port.
module imem_sync #(
  parameter int          IMEM_W     = 13,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] ERR_DATA   = 32'h0000_0013,
  parameter string       INIT_FILE  = ""
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_addr_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_data_o,
  output logic              resp_err_o,
  input  logic              we_i,
  input  logic [IMEM_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        wstrb_i
);

  localparam int DEPTH = 2 ** (IMEM_W - 2);
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rd_word;
  logic                  r_rd_err;
  logic                  r_inflight;
  logic [31:0]           r_fdata [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_ferr;
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;

  logic [31:0]       w_off;
  logic              w_err;
  logic [IMEM_W-3:0] w_ridx;
  logic [IMEM_W-3:0] w_widx;
  logic              w_acc;
  logic              w_empty;
  logic              w_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_fpop;
  logic [31:0]       w_rd_data;
  logic [CW:0]       w_used;
  logic              w_unused;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign w_off  = req_addr_i - BASE_ADDR;
  assign w_err  = (req_addr_i[1:0] != 2'b00) ||
                  ({1'b0, w_off} >= (33'd1 << IMEM_W));
  assign w_ridx = w_off[IMEM_W-1:2];
  assign w_widx = waddr_i[IMEM_W-1:2];
  assign w_unused = &{1'b0, waddr_i[1:0]};

  // Occupancy counts the read in flight so the FIFO can never overflow.
  assign w_used      = {1'b0, r_cnt} + (CW+1)'(r_inflight);
  assign req_ready_o = !rst_i && !flush_i &&
                       (w_used < (CW+1)'(FIFO_DEPTH));
  assign w_acc       = req_valid_i && req_ready_o;

  assign w_empty   = (r_cnt == '0);
  assign w_valid   = !w_empty || r_inflight;
  assign w_pop     = w_valid && resp_ready_i;
  assign w_fpop    = w_pop && !w_empty;
  assign w_push    = r_inflight && !(w_empty && w_pop);
  assign w_rd_data = r_rd_err ? ERR_DATA : r_rd_word;

  assign resp_valid_o = w_valid;

  always_comb begin
    resp_data_o = 32'h0;
    resp_err_o  = 1'b0;
    if (!w_empty) begin
      resp_data_o = r_fdata[r_rptr];
      resp_err_o  = r_ferr[r_rptr];
    end else if (r_inflight) begin
      resp_data_o = w_rd_data;
      resp_err_o  = r_rd_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we_i && !rst_i) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb_i[k]) r_mem[w_widx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  // Read-first: the read samples the array before this edge's write lands.
  always_ff @(posedge clk_i) begin
    if (w_acc && !w_err) r_rd_word <= r_mem[w_ridx];
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fdata[r_wptr] <= w_rd_data;
      r_ferr[r_wptr]  <= r_rd_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inflight <= 1'b0;
      r_rd_err   <= 1'b0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (flush_i) begin
      r_inflight <= 1'b0;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_inflight <= w_acc;
      if (w_acc) r_rd_err <= w_err;
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_fpop) r_rptr <= ptr_inc(r_rptr);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_fpop);
    end
  end

endmodule
